// File: rtl/ushift_pkg.sv
// rtl/ushift_pkg.sv - mode constants and burst FSM state encoding for ushift_reg
package ushift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/ushift_cell.sv
// rtl/ushift_cell.sv - one register bit: 4:1 source mux plus flop with synchronous clear
module ushift_cell
  import ushift_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [1:0] sel_i,
  input  logic       shr_src_i,
  input  logic       shl_src_i,
  input  logic       load_src_i,
  output logic       q_o
);

  logic bit_q;
  logic bit_d;

  // Select the next value of this bit from hold, either neighbour, or parallel data
  always_comb begin
    bit_d = bit_q;
    case (sel_i)
      MODE_HOLD: bit_d = bit_q;
      MODE_SHR:  bit_d = shr_src_i;
      MODE_SHL:  bit_d = shl_src_i;
      MODE_LOAD: bit_d = load_src_i;
      default:   bit_d = bit_q;
    endcase
  end

  // Bit storage; clear wins over every mux selection
  always_ff @(posedge clock) begin
    if (clear) begin
      bit_q <= RESET_BIT;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q_o = bit_q;

endmodule

// File: rtl/ushift_reg.sv
// rtl/ushift_reg.sv - universal shift register with rotate, serial I/O and counted burst shifts
module ushift_reg
  import ushift_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter int                 CNT_W     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic [WIDTH-1:0] data,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             serial_out_left,
  output logic             serial_out_right,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_left_q, dir_left_d;
  logic             rot_q, rot_d;

  logic [1:0]       op_sel;
  logic             rot_eff;
  logic             fill_msb;
  logic             fill_lsb;

  // Burst FSM: decides which operation the cell array performs this edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    rot_d      = rot_q;
    op_sel     = MODE_HOLD;
    rot_eff    = rotate;
    case (state_q)
      ST_IDLE: begin
        if (start && (mode == MODE_SHR || mode == MODE_SHL)) begin
          // The accepting edge only captures the burst parameters; no shift yet
          dir_left_d = (mode == MODE_SHL);
          rot_d      = rotate;
          cnt_d      = count;
          state_d    = (count != '0) ? ST_SHIFT : ST_DONE;
        end else begin
          op_sel = mode;
        end
      end
      ST_SHIFT: begin
        op_sel  = dir_left_q ? MODE_SHL : MODE_SHR;
        rot_eff = rot_q;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and latched burst parameters; clear aborts any burst silently
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
      rot_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_left_q <= dir_left_d;
      rot_q      <= rot_d;
    end
  end

  // Vacated-bit fill: the bit falling off the other end when rotating, else the serial input
  always_comb begin
    fill_msb = rot_eff ? q[0]       : serial_in_left;
    fill_lsb = rot_eff ? q[WIDTH-1] : serial_in_right;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic shr_src;
    logic shl_src;
    if (i == WIDTH - 1) begin : g_msb
      assign shr_src = fill_msb;
    end else begin : g_mid_r
      assign shr_src = q[i+1];
    end
    if (i == 0) begin : g_lsb
      assign shl_src = fill_lsb;
    end else begin : g_mid_l
      assign shl_src = q[i-1];
    end
    ushift_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clock      (clock),
      .clear      (clear),
      .sel_i      (op_sel),
      .shr_src_i  (shr_src),
      .shl_src_i  (shl_src),
      .load_src_i (data[i]),
      .q_o        (q[i])
    );
  end

  assign qbar             = ~q;
  assign serial_out_left  = q[WIDTH-1];
  assign serial_out_right = q[0];
  assign busy             = (state_q == ST_SHIFT);
  assign done             = (state_q == ST_DONE);

endmodule

// File: tb/tb_ushift_reg.sv
// tb/tb_ushift_reg.sv - randomized and directed self-checking bench for ushift_reg
module tb_ushift_reg;

  logic       clock;
  logic       clear;
  logic [1:0] mode;
  logic       rotate;
  logic [7:0] data;
  logic       serial_in_left;
  logic       serial_in_right;
  logic       start;
  logic [7:0] count;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       serial_out_left;
  logic       serial_out_right;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 0;

  // reference state: register word, shifts still owed by a burst, pending done
  int m_q    = 0;
  int m_left = 0;
  bit m_done = 0;
  bit m_dir_left = 0;
  bit m_rot = 0;

  ushift_reg #(.WIDTH(8), .CNT_W(8), .RESET_VAL(8'h00)) dut (
    .clock            (clock),
    .clear            (clear),
    .mode             (mode),
    .rotate           (rotate),
    .data             (data),
    .serial_in_left   (serial_in_left),
    .serial_in_right  (serial_in_right),
    .start            (start),
    .count            (count),
    .q                (q),
    .qbar             (qbar),
    .serial_out_left  (serial_out_left),
    .serial_out_right (serial_out_right),
    .busy             (busy),
    .done             (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int shift_word(input int v, input bit left, input bit rot,
                                    input bit sil, input bit sir);
    int fill;
    if (!left) begin
      fill = rot ? (v % 2) : int'(sil);
      return (v / 2) + fill * 128;
    end
    fill = rot ? (v / 128) : int'(sir);
    return ((v * 2) % 256) + fill;
  endfunction

  // Advance the reference by one edge using the inputs currently driven, then wait for the edge
  task automatic tick();
    int nq, nleft;
    bit ndone, ndir, nrot;
    nq = m_q; nleft = m_left; ndone = 0; ndir = m_dir_left; nrot = m_rot;
    if (clear) begin
      nq = 0; nleft = 0; ndone = 0;
    end else if (m_done) begin
      ndone = 0;
    end else if (m_left > 0) begin
      nq = shift_word(m_q, m_dir_left, m_rot, serial_in_left, serial_in_right);
      nleft = m_left - 1;
      ndone = (nleft == 0);
    end else if (start && (mode == 2'b01 || mode == 2'b10)) begin
      ndir = (mode == 2'b10);
      nrot = rotate;
      nleft = int'(count);
      ndone = (count == 0);
    end else begin
      case (mode)
        2'b01: nq = shift_word(m_q, 0, rotate, serial_in_left, serial_in_right);
        2'b10: nq = shift_word(m_q, 1, rotate, serial_in_left, serial_in_right);
        2'b11: nq = int'(data);
        default: nq = m_q;
      endcase
    end
    @(posedge clock);
    m_q = nq; m_left = nleft; m_done = ndone; m_dir_left = ndir; m_rot = nrot;
    @(negedge clock);
    #1;
  endtask

  // Every-cycle comparison of all outputs against the reference
  always @(negedge clock) begin
    if (check_en) begin
      chk("q", int'(q), m_q);
      chk("qbar", int'(qbar), 255 - m_q);
      chk("serial_out_left", int'(serial_out_left), m_q / 128);
      chk("serial_out_right", int'(serial_out_right), m_q % 2);
      chk("busy", int'(busy), int'(m_left > 0));
      chk("done", int'(done), int'(m_done));
      chk("busy_and_done", int'(busy & done), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int done_cycles;
    clear = 1; mode = 0; rotate = 0; data = 0; serial_in_left = 0;
    serial_in_right = 0; start = 0; count = 0;
    @(negedge clock); #1;
    tick();
    check_en = 1;
    tick();
    chk("reset_q", int'(q), 8'h00);
    chk("reset_qbar", int'(qbar), 8'hFF);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sol", int'(serial_out_left), 0);
    chk("reset_sor", int'(serial_out_right), 0);

    clear = 0; mode = 2'b11; data = 8'hA5;
    tick();
    chk("load_q", int'(q), 8'hA5);
    chk("load_qbar", int'(qbar), 8'h5A);
    mode = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    chk("hold_q", int'(q), 8'hA5);

    rotate = 0; serial_in_left = 1; mode = 2'b01;
    chk("shr_sor_before", int'(serial_out_right), 1);
    tick();
    chk("shr_q", int'(q), 8'hD2);
    chk("shr_sor_after", int'(serial_out_right), 0);

    mode = 2'b11; data = 8'h81; tick();
    start = 1; mode = 2'b10; rotate = 1; count = 8'd3;
    tick();
    start = 0; mode = 2'b00; rotate = 0;
    chk("burst_accept_q", int'(q), 8'h81);
    busy_cycles = int'(busy); done_cycles = 0;
    tick(); chk("burst_q1", int'(q), 8'h03); busy_cycles += int'(busy);
    tick(); chk("burst_q2", int'(q), 8'h06); busy_cycles += int'(busy);
    tick(); chk("burst_q3", int'(q), 8'h0C); done_cycles += int'(done);
    tick(); chk("burst_q_after", int'(q), 8'h0C); done_cycles += int'(done);
    chk("burst_busy_cycles", busy_cycles, 3);
    chk("burst_done_pulses", done_cycles, 1);

    start = 1; mode = 2'b01; count = 8'd0;
    tick();
    start = 0; mode = 2'b00;
    chk("zero_busy", int'(busy), 0);
    chk("zero_done", int'(done), 1);
    chk("zero_q", int'(q), 8'h0C);
    tick();
    chk("zero_done_clear", int'(done), 0);

    mode = 2'b11; data = 8'h81; tick();
    start = 1; mode = 2'b10; rotate = 1; count = 8'd10;
    tick();
    start = 0; mode = 2'b00; rotate = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("rot10_q", int'(q), 8'h06);
    chk("rot10_done", int'(done), 1);
    tick();

    start = 1; mode = 2'b01; count = 8'd5; serial_in_left = 1;
    tick();
    start = 0; mode = 2'b00;
    tick();
    clear = 1;
    tick();
    clear = 0;
    chk("abort_q", int'(q), 8'h00);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    start = 1; mode = 2'b10; count = 8'd2;
    tick();
    start = 0; mode = 2'b00;
    chk("restart_busy", int'(busy), 1);
    tick(); tick();
    chk("restart_done", int'(done), 1);
    tick();

    for (int i = 0; i < 600; i++) begin
      clear = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 3) == 0);
      mode = 2'($urandom_range(0, 3));
      rotate = 1'($urandom_range(0, 1));
      serial_in_left = 1'($urandom_range(0, 1));
      serial_in_right = 1'($urandom_range(0, 1));
      data = 8'($urandom);
      count = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40))
                                          : 8'($urandom_range(0, 5));
      tick();
    end

    check_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
